// File: rtl/stopwatch_cu.sv
// stopwatch_cu: RUN/STOP/CLEAR sequencer for the stopwatch datapath.
// Events come from debounced buttons and ASCII commands in the UART RX FIFO.
module stopwatch_cu (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_run_stop,
    input  logic       btn_clear,
    input  logic       rx_empty,
    input  logic [7:0] rx_rdata,
    output logic       rx_rd,
    input  logic       tx_full,
    output logic       tx_push,
    output logic [7:0] tx_wdata,
    output logic       run_stop,
    output logic       clear
);

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_EVAL = 1'b1
    } rd_t;

    localparam logic [7:0] ACK_RS  = 8'h52;
    localparam logic [7:0] ACK_CL  = 8'h43;
    localparam logic [7:0] ACK_SP  = 8'h53;
    localparam logic [7:0] ACK_BAD = 8'h3F;

    state_t     state;
    state_t     state_nxt;
    rd_t        rd_state;
    rd_t        rd_nxt;

    logic       cmd_rs;
    logic       cmd_cl;
    logic       cmd_sp;
    logic       btn_any;
    logic       uart_take;
    logic       ev_rs;
    logic       ev_cl;
    logic       ev_sp;
    logic       ack_push;
    logic [7:0] ack_code;

    // Decode the byte sampled in EVAL; case is folded by matching both codes.
    always_comb begin
        cmd_rs = (rx_rdata == 8'h52) || (rx_rdata == 8'h72);
        cmd_cl = (rx_rdata == 8'h43) || (rx_rdata == 8'h63);
        cmd_sp = (rx_rdata == 8'h53) || (rx_rdata == 8'h73);
    end

    // Merge sources: buttons beat the UART byte, and clear beats run/stop.
    always_comb begin
        btn_any   = btn_run_stop | btn_clear;
        uart_take = (rd_state == RD_EVAL) & ~btn_any;
        ev_cl     = btn_clear | (uart_take & cmd_cl);
        ev_rs     = (btn_run_stop & ~btn_clear) | (uart_take & cmd_rs);
        ev_sp     = uart_take & cmd_sp;
    end

    // Acknowledgement for a byte that was actually evaluated.
    always_comb begin
        ack_push = uart_take & ~tx_full;
        if (cmd_rs)
            ack_code = ACK_RS;
        else if (cmd_cl)
            ack_code = ACK_CL;
        else if (cmd_sp)
            ack_code = ACK_SP;
        else
            ack_code = ACK_BAD;
    end

    // Control FSM and reader state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_STOP;
            rd_state <= RD_IDLE;
        end else begin
            state    <= state_nxt;
            rd_state <= rd_nxt;
        end
    end

    // Control FSM next state; CLEAR is a one-cycle transient.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_STOP: begin
                if (ev_cl)
                    state_nxt = ST_CLEAR;
                else if (ev_rs)
                    state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (ev_rs || ev_sp)
                    state_nxt = ST_STOP;
            end
            ST_CLEAR: state_nxt = ST_STOP;
            default:  state_nxt = ST_STOP;
        endcase
    end

    // Reader next state: pop in IDLE, evaluate the byte the cycle after.
    always_comb begin
        rd_nxt = rd_state;
        case (rd_state)
            RD_IDLE: begin
                if (!rx_empty)
                    rd_nxt = RD_EVAL;
            end
            RD_EVAL: rd_nxt = RD_IDLE;
            default: rd_nxt = RD_IDLE;
        endcase
    end

    // Outputs decoded from registered state; no pop while held in reset.
    always_comb begin
        run_stop = (state == ST_RUN);
        clear    = (state == ST_CLEAR);
        rx_rd    = rst & (rd_state == RD_IDLE) & ~rx_empty;
    end

    // Registered TX push; the data byte holds its last value between pushes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_push  <= 1'b0;
            tx_wdata <= 8'h00;
        end else begin
            tx_push <= ack_push;
            if (ack_push)
                tx_wdata <= ack_code;
        end
    end

endmodule

// File: tb/tb_stopwatch_cu.sv
// tb_stopwatch_cu: scoreboard bench for stopwatch_cu.
// Expected TX bytes are queued when RX bytes are fed and popped on tx_push.
module tb_stopwatch_cu;

    logic       clk;
    logic       rst;
    logic       btn_run_stop;
    logic       btn_clear;
    logic       rx_empty;
    logic [7:0] rx_rdata;
    logic       rx_rd;
    logic       tx_full;
    logic       tx_push;
    logic [7:0] tx_wdata;
    logic       run_stop;
    logic       clear;

    int n_vec;
    int n_err;

    logic [7:0] rx_q[$];
    logic [7:0] sb_q[$];
    logic       prev_rd;

    stopwatch_cu dut (
        .clk          (clk),
        .rst          (rst),
        .btn_run_stop (btn_run_stop),
        .btn_clear    (btn_clear),
        .rx_empty     (rx_empty),
        .rx_rdata     (rx_rdata),
        .rx_rd        (rx_rd),
        .tx_full      (tx_full),
        .tx_push      (tx_push),
        .tx_wdata     (tx_wdata),
        .run_stop     (run_stop),
        .clear        (clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // RX FIFO model: data appears the cycle after the pop strobe.
    initial begin
        rx_empty = 1'b1;
        rx_rdata = 8'h00;
    end
    always @(posedge clk) begin
        if (rx_rd && rx_q.size() > 0)
            rx_rdata <= rx_q.pop_front();
        rx_empty <= ((rx_q.size() - (rx_rd ? 1 : 0)) <= 0);
    end

    // TX monitor and protocol watchers, sampled on the falling edge.
    initial prev_rd = 1'b0;
    always @(negedge clk) begin
        if (tx_push) begin
            check("tx_while_full", tx_full, 0);
            if (sb_q.size() == 0)
                check("tx_unexpected", {24'h0, tx_wdata}, 32'hFFFF_FFFF);
            else
                check("tx_byte", tx_wdata, sb_q.pop_front());
        end
        if (rx_rd)
            check("rd_back_to_back", prev_rd, 0);
        prev_rd = rx_rd;
    end

    task automatic send(input logic [7:0] b, input bit expect_ack,
                        input logic [7:0] ack);
        rx_q.push_back(b);
        if (expect_ack)
            sb_q.push_back(ack);
    endtask

    task automatic wait_rd();
        int k;
        k = 0;
        while (!rx_rd && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!rx_rd)
            check("rd_timeout", 0, 1);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((sb_q.size() != 0 || rx_q.size() != 0) && k < 50) begin
            @(negedge clk);
            k++;
        end
        repeat (4) @(negedge clk);
        check("drain_sb", sb_q.size(), 0);
    endtask

    initial begin
        int pops[$];
        int rise;
        int nclr;

        n_vec        = 0;
        n_err        = 0;
        rst          = 1'b0;
        btn_run_stop = 1'b0;
        btn_clear    = 1'b0;
        tx_full      = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_run_stop", run_stop, 0);
        check("rst_clear", clear, 0);
        check("rst_rx_rd", rx_rd, 0);
        check("rst_tx_push", tx_push, 0);
        check("rst_tx_wdata", tx_wdata, 0);
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_run_stop", run_stop, 0);
            check("idle_clear", clear, 0);
            check("idle_rx_rd", rx_rd, 0);
            check("idle_tx_push", tx_push, 0);
        end

        // Button timeline: run/stop at 5 and 20, clear at 30
        for (int c = 0; c < 36; c++) begin
            check("btn_run_stop", run_stop, (c >= 6 && c <= 20) ? 1 : 0);
            check("btn_clear", clear, (c == 31) ? 1 : 0);
            btn_run_stop = (c == 5 || c == 20);
            btn_clear    = (c == 30);
            @(negedge clk);
        end
        btn_run_stop = 1'b0;
        btn_clear    = 1'b0;

        // UART "r","x","C" from STOP
        send(8'h72, 1, 8'h52);
        send(8'h78, 1, 8'h3F);
        send(8'h43, 1, 8'h43);
        rise = -1;
        nclr = 0;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (rx_rd)
                pops.push_back(c);
            if (run_stop && rise < 0)
                rise = c;
            if (clear)
                nclr++;
        end
        check("uart_pop_count", pops.size(), 3);
        if (pops.size() == 3) begin
            check("uart_pop_gap1", pops[1] - pops[0], 2);
            check("uart_pop_gap2", pops[2] - pops[1], 2);
            check("uart_rise_lat", rise - pops[0], 2);
        end
        check("uart_no_clear", nclr, 0);
        check("uart_running", run_stop, 1);
        drain();

        // 's' stops the clock
        send(8'h73, 1, 8'h53);
        drain();
        check("sp_stopped", run_stop, 0);

        // 'C' with TX full: clear still happens, ack dropped
        tx_full = 1'b1;
        send(8'h43, 0, 8'h00);
        nclr = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (clear) begin
                nclr++;
                check("full_clr_rs", run_stop, 0);
            end
        end
        check("full_clear_pulses", nclr, 1);
        tx_full = 1'b0;

        // 'S' in STOP: no state change, ack sent
        send(8'h53, 1, 8'h53);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("sp_in_stop_rs", run_stop, 0);
            check("sp_in_stop_clr", clear, 0);
        end
        drain();

        // Button coincides with EVAL of 'S' in STOP
        send(8'h53, 0, 8'h00);
        wait_rd();
        @(negedge clk);
        btn_run_stop = 1'b1;
        @(negedge clk);
        btn_run_stop = 1'b0;
        check("coinc_run", run_stop, 1);
        repeat (4) @(negedge clk);
        check("coinc_still_run", run_stop, 1);

        // Async reset while RUN with an EVAL pending
        send(8'h53, 0, 8'h00);
        wait_rd();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("arst_run_stop", run_stop, 0);
        check("arst_tx_push", tx_push, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("arst_stays_stop", run_stop, 0);
        send(8'h52, 1, 8'h52);
        wait_rd();
        repeat (2) @(negedge clk);
        check("arst_resume_run", run_stop, 1);
        drain();

        // Both buttons in STOP: clear wins
        btn_run_stop = 1'b1;
        @(negedge clk);
        btn_run_stop = 1'b0;
        check("both_pre_stop", run_stop, 0);
        btn_run_stop = 1'b1;
        btn_clear    = 1'b1;
        @(negedge clk);
        btn_run_stop = 1'b0;
        btn_clear    = 1'b0;
        check("both_clear", clear, 1);
        check("both_rs", run_stop, 0);
        @(negedge clk);
        check("both_clear_end", clear, 0);
        check("both_rs_after", run_stop, 0);

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/stopwatch_cu.md
# stopwatch_cu

Control unit that sequences the stopwatch datapath's `run_stop` and `clear` inputs from two sources: debounced push-button pulses and ASCII command bytes read from the UART RX FIFO. It owns the RUN/STOP/CLEAR state machine. It pops the RX FIFO one byte at a time and pushes a one-byte acknowledgement into the UART TX FIFO. It sits between the button debouncers, the UART FIFO pair and the stopwatch datapath.

## Interface
Parameters:
- none; command codes are fixed as listed under Operation.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  reset, asynchronous, active-low (0 = reset).
- `btn_run_stop`  in  1  debounced single-cycle pulse; toggles run/stop.
- `btn_clear`  in  1  debounced single-cycle pulse; requests clear.
- `rx_empty`  in  1  RX FIFO empty flag.
- `rx_rdata`  in  8  RX FIFO read data; valid the cycle after `rx_rd`.
- `rx_rd`  out  1  RX FIFO pop strobe, one cycle per byte.
- `tx_full`  in  1  TX FIFO full flag.
- `tx_push`  out  1  TX FIFO push strobe.
- `tx_wdata`  out  8  acknowledgement byte; valid with `tx_push`.
- `run_stop`  out  1  level to the datapath; 1 = counting.
- `clear`  out  1  single-cycle clear pulse to the datapath.

## Operation
- Control FSM states:
  - STOP (reset state).
  - RUN.
  - CLEAR: transient, lasts exactly one cycle, then goes to STOP.
- Events: RS = run/stop toggle; CL = clear; SP = explicit stop.
- Transitions:
  - STOP + RS -> RUN.
  - RUN + RS -> STOP.
  - RUN + SP -> STOP.
  - STOP + CL -> CLEAR.
  - RUN + CL: ignored; the clock keeps running.
  - STOP + SP: no change.
  - An event arriving while in CLEAR is dropped.
- Outputs are registered:
  - `run_stop` = (state == RUN).
  - `clear` = (state == CLEAR).
- Command reader, two phases (IDLE, EVAL):
  - IDLE: if `rx_empty` == 0, assert `rx_rd` combinationally this cycle and go to EVAL.
  - EVAL: sample `rx_rdata`, decode it, and never assert `rx_rd`. Return to IDLE.
  - Maximum throughput is one byte per 2 cycles.
- Decode table; upper and lower case are equivalent:
  - 'R' (0x52) / 'r' (0x72) -> RS.
  - 'C' (0x43) / 'c' (0x63) -> CL.
  - 'S' (0x53) / 's' (0x73) -> SP.
  - Any other byte -> no event.
- Priority when a button pulse and an EVAL cycle coincide:
  - The button event is applied.
  - The UART byte has already been popped and is discarded. No acknowledgement is sent.
  - If both buttons pulse in the same cycle, `btn_clear` wins.
- Acknowledgement, issued in the EVAL cycle:
  - Valid command: push the uppercase code ('R', 'C' or 'S'). This applies even when the event is ignored by the FSM (e.g. 'C' while in RUN).
  - Unrecognised byte: push '?' (0x3F).
  - If `tx_full` = 1, the acknowledgement is dropped; the state change still happens.
  - `tx_push` is never asserted while `tx_full` = 1.
- Reset mid-operation:
  - FSM returns to STOP and the reader to IDLE.
  - A byte popped but not yet evaluated is lost.

## Timing
- Reset values: `run_stop` = 0, `clear` = 0, `rx_rd` = 0, `tx_push` = 0, `tx_wdata` = 0x00.
- Button pulse in cycle N -> new `run_stop` / `clear` visible at cycle N+1.
- UART path:
  - `rx_empty` = 0 in cycle N -> `rx_rd` = 1 in cycle N.
  - EVAL at N+1.
  - State effect visible at N+2.
- `tx_push` / `tx_wdata` are registered and asserted in cycle N+2, for one cycle.
- `clear` is high for exactly one cycle. `run_stop` is 0 during that cycle and during the cycle after it.
- `rx_rd` is never asserted in two consecutive cycles.

## Test plan
- Reset, then hold `rst` = 1 for 10 cycles -> `run_stop` = 0, `clear` = 0, `rx_rd` = 0, `tx_push` = 0 throughout.
- Pulse `btn_run_stop` at cycle 5, then again at cycle 20 -> `run_stop` = 1 over cycles 6–20 and 0 from cycle 21. Then pulse `btn_clear` at cycle 30 -> `clear` = 1 at cycle 31 only.
- RX FIFO holds "r", "x", "C" (0x72, 0x78, 0x43) with `tx_full` = 0:
  - Three `rx_rd` pulses, 2 cycles apart.
  - `run_stop` rises 2 cycles after the first pop.
  - TX receives 0x52, 0x3F, 0x43.
  - No `clear` pulse, because the FSM is in RUN when 'C' arrives.
- In STOP, send "C" with `tx_full` = 1 -> `clear` pulses for one cycle, `tx_push` stays 0. Follow with "S" -> no state change, TX receives 0x53 (`tx_full` now 0).
- `btn_run_stop` pulse coincides with the EVAL cycle of an 'S' byte while in STOP -> state goes to RUN, 'S' is discarded, no `tx_push`.
- Assert `rst` = 0 for one cycle while in RUN with an EVAL pending -> `run_stop` = 0 immediately (asynchronous), no `tx_push`, and the reader resumes popping once `rst` = 1.
